// File: rtl/seg_disp_pkg.sv
// Shared codes, state type and helpers for the 7-segment display writer path.
package seg_disp_pkg;

  localparam logic [7:0] SEG_BLANK_CODE = 8'h10;
  localparam logic [7:0] SEG_ERR_CODE   = 8'h0E;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    WRITE
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, DATA_W steps
// after a start pulse, done pulses in the cycle of the final step.
module bin_to_bcd_seq #(
  parameter int DATA_W     = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       value_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]       bin_reg;
  logic [BCD_W-1:0]        bcd_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    running_reg;
  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+DATA_W-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // Top bit falls off the concatenation; values that need it are flagged as overflow upstream.
  assign shifted = {bcd_adj, bin_reg} << 1;
  assign done_o  = running_reg && (cnt_reg == CNT_W'(DATA_W - 1));
  assign bcd_o   = bcd_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg     <= '0;
      bcd_reg     <= '0;
      cnt_reg     <= '0;
      running_reg <= 1'b0;
    end else if (start_i) begin
      bin_reg     <= value_i;
      bcd_reg     <= '0;
      cnt_reg     <= '0;
      running_reg <= 1'b1;
    end else if (running_reg) begin
      bin_reg <= shifted[DATA_W-1:0];
      bcd_reg <= shifted[BCD_W+DATA_W-1:DATA_W];
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (done_o) begin
        running_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bin_to_seg_avalon_writer.sv
// Accepts a binary value, converts it to BCD and writes one Avalon-MM beat per digit.
// Define SEG_LEADING_ZERO_BLANK_EN to blank digits above the most significant nonzero one.
module bin_to_seg_avalon_writer
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] value_i,
  input  logic              value_valid_i,
  output logic              value_ready_o,
  output logic [2:0]        avm_address_o,
  output logic              avm_write_o,
  output logic [7:0]        avm_writedata_o,
  input  logic              avm_waitrequest_i,
  output logic              busy_o,
  output logic              overflow_o
);

  localparam int          BCD_W     = 4 * NUM_DIGITS;
  localparam logic [63:0] MAX_VALUE = pow10(NUM_DIGITS) - 64'd1;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_digits_check
      $error("NUM_DIGITS must be in 1..8 for a 3-bit digit address");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [2:0]       beat_reg, beat_next;
  logic             overflow_reg;
  logic             accept;
  logic             conv_done;
  logic             beat_done;
  logic             last_beat;
  logic [BCD_W-1:0] bcd;
  logic [7:0]       digit_code [8];

  assign accept    = value_valid_i && (state_reg == IDLE);
  assign beat_done = (state_reg == WRITE) && !avm_waitrequest_i;
  assign last_beat = (beat_reg == 3'(NUM_DIGITS - 1));

  bin_to_bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept),
    .value_i (value_i),
    .done_o  (conv_done),
    .bcd_o   (bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (accept) begin
        overflow_reg <= (64'(value_i) > MAX_VALUE);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = CONVERT;
      end
      CONVERT: begin
        if (conv_done) state_next = WRITE;
      end
      WRITE: begin
        if (beat_done) begin
          if (last_beat) begin
            state_next = IDLE;
            beat_next  = '0;
          end else begin
            beat_next = beat_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Per-digit write codes; unused address slots read as zero.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_code
      if (gi >= NUM_DIGITS) begin : g_unused
        assign digit_code[gi] = 8'h00;
      end else if (gi == 0) begin : g_lsd
        assign digit_code[gi] = overflow_reg ? SEG_ERR_CODE : {4'h0, bcd[3:0]};
      end else begin : g_upper
        logic upper_zero;
        assign upper_zero     = (bcd[BCD_W-1:4*gi] == '0);
        assign digit_code[gi] = overflow_reg            ? SEG_ERR_CODE   :
                                (BLANK_EN && upper_zero) ? SEG_BLANK_CODE :
                                {4'h0, bcd[4*gi +: 4]};
      end
    end
  endgenerate

  assign value_ready_o   = (state_reg == IDLE);
  assign busy_o          = !value_ready_o;
  assign avm_write_o     = (state_reg == WRITE);
  assign avm_address_o   = beat_reg;
  assign avm_writedata_o = avm_write_o ? digit_code[beat_reg] : 8'h00;
  assign overflow_o      = overflow_reg;

endmodule
